// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a Start/Done handshake.
//   Base RV32I ops (add/sub/logic/compare/shift) write Result and flags at the
//   accept edge, so Done follows one cycle later. M-extension ops (mul/mulh*/
//   div*/rem*) run an iterative 1-bit-per-cycle datapath with fixed latency,
//   and Done arrives in cycle WIDTH+1.
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   Start             op request, taken only while Busy=0
//   A, B, ALUControl  operands and 5-bit op code, captured at accept
//   Busy              iterative op in flight (Start ignored)
//   Done              one-cycle pulse when Result and flags update
//   Result            registered result, held until the next Done
//   Zero, Overflow, Negative, CarryOUT   status flags for the written Result
//
// state | meaning
// IDLE  | waiting for Start; base ops complete here in a single edge
// CALC  | one shift-add / restoring-subtract step per edge
// FIX   | sign correction, Result/flags written, Done raised
module alu_seq #(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       ALUControl,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             Negative,
    output logic             CarryOUT
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 2);
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_AND = 5'b00010,
                           OP_OR  = 5'b00011, OP_XOR = 5'b00100, OP_SLT = 5'b00101,
                           OP_SLTU = 5'b00110, OP_SLL = 5'b00111, OP_SRL = 5'b01000,
                           OP_SRA = 5'b01001, OP_MULH = 5'b10001, OP_MULHSU = 5'b10010,
                           OP_DIV = 5'b10100, OP_REM = 5'b10110;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
    state_t state, state_nxt;

    logic             accept, op_md;
    logic [WIDTH:0]   add_w, sub_w;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] base_res;
    logic             base_ovf, base_cy;

    logic             a_signed, b_signed, sa_in, sb_in;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic [WIDTH-1:0] hi_r, lo_r, opd_r;
    logic [2:0]       op_r;
    logic             sa_r, sb_r, div0_r, ovf_r;
    logic [SHW-1:0]   cnt_r;

    logic [WIDTH-1:0] st_hi, st_lo, st_opd;
    logic             st_div;
    logic [2*WIDTH-1:0] step_out, prod;
    logic [WIDTH-1:0] quo, rem, fix_res;

    assign accept = Start && (state == S_IDLE);
    assign op_md  = MULDIV_EN && (ALUControl[4:3] == 2'b10);
    assign Busy   = (state != S_IDLE);

    // Base ALU
    assign add_w   = {1'b0, A} + {1'b0, B};
    assign sub_w   = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        base_res = '0;
        base_ovf = 1'b0;
        base_cy  = 1'b0;
        case (ALUControl)
            OP_ADD:  begin base_res = add_w[WIDTH-1:0]; base_ovf = add_ovf; base_cy = add_w[WIDTH]; end
            OP_SUB:  begin base_res = sub_w[WIDTH-1:0]; base_ovf = sub_ovf; base_cy = sub_w[WIDTH]; end
            OP_AND:  base_res = A & B;
            OP_OR:   base_res = A | B;
            OP_XOR:  base_res = A ^ B;
            OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, sub_w[WIDTH-1] ^ sub_ovf};
            OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, ~sub_w[WIDTH]};
            OP_SLL:  base_res = A << B[SHW-1:0];
            OP_SRL:  base_res = A >> B[SHW-1:0];
            OP_SRA:  base_res = $signed(A) >>> B[SHW-1:0];
            default: base_res = '0;
        endcase
    end

    // Mul/div operate on magnitudes; signs are reapplied in FIX.
    assign a_signed = (ALUControl == OP_MULH) || (ALUControl == OP_MULHSU) ||
                      (ALUControl == OP_DIV)  || (ALUControl == OP_REM);
    assign b_signed = (ALUControl == OP_MULH) || (ALUControl == OP_DIV) ||
                      (ALUControl == OP_REM);
    assign sa_in = a_signed && A[WIDTH-1];
    assign sb_in = b_signed && B[WIDTH-1];
    assign mag_a = sa_in ? -A : A;
    assign mag_b = sb_in ? -B : B;

    // hi/lo hold {accumulator, multiplier} for mul and {remainder, quotient} for div.
    function automatic logic [2*WIDTH-1:0] md_step(input logic is_div,
                                                   input logic [WIDTH-1:0] hi,
                                                   input logic [WIDTH-1:0] lo,
                                                   input logic [WIDTH-1:0] opd);
        logic [WIDTH:0] s;
        if (!is_div) begin
            s = {1'b0, hi} + (lo[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
            return {s, lo[WIDTH-1:1]};
        end
        s = {hi, lo[WIDTH-1]} - {1'b0, opd};
        if (!s[WIDTH])
            return {s[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
        return {hi[WIDTH-2:0], lo[WIDTH-1], lo[WIDTH-2:0], 1'b0};
    endfunction

    // The first step runs on the accept edge straight from the input
    // magnitudes, so WIDTH steps plus FIX fit in a Done at cycle WIDTH+1.
    always_comb begin
        st_hi  = hi_r;
        st_lo  = lo_r;
        st_opd = opd_r;
        st_div = op_r[2];
        if (state == S_IDLE) begin
            st_hi  = '0;
            st_lo  = ALUControl[2] ? mag_a : mag_b;
            st_opd = ALUControl[2] ? mag_b : mag_a;
            st_div = ALUControl[2];
        end
    end

    assign step_out = md_step(st_div, st_hi, st_lo, st_opd);

    always_comb begin
        prod = {hi_r, lo_r};
        if (sa_r ^ sb_r)
            prod = -prod;
        quo = lo_r;
        if (div0_r)
            quo = '1;
        else if (sa_r ^ sb_r)
            quo = -lo_r;
        rem = sa_r ? -hi_r : hi_r;
        if (!op_r[2])
            fix_res = (op_r[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        else
            fix_res = op_r[1] ? rem : quo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && op_md) state_nxt = S_CALC;
            S_CALC:  if (cnt_r == CNT_LAST) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r   <= '0;
            lo_r   <= '0;
            opd_r  <= '0;
            op_r   <= '0;
            sa_r   <= 1'b0;
            sb_r   <= 1'b0;
            div0_r <= 1'b0;
            ovf_r  <= 1'b0;
            cnt_r  <= '0;
        end else if (accept && op_md) begin
            {hi_r, lo_r} <= step_out;
            opd_r  <= st_opd;
            op_r   <= ALUControl[2:0];
            sa_r   <= sa_in;
            sb_r   <= sb_in;
            div0_r <= (B == '0);
            ovf_r  <= ((ALUControl == OP_DIV) || (ALUControl == OP_REM)) &&
                      (A == MIN_VAL) && (B == '1);
            cnt_r  <= '0;
        end else if (state == S_CALC) begin
            {hi_r, lo_r} <= step_out;
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result   <= '0;
            Zero     <= 1'b0;
            Overflow <= 1'b0;
            Negative <= 1'b0;
            CarryOUT <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (accept && !op_md) begin
                Result   <= base_res;
                Zero     <= (base_res == '0);
                Negative <= base_res[WIDTH-1];
                Overflow <= base_ovf;
                CarryOUT <= base_cy;
                Done     <= 1'b1;
            end else if (state == S_FIX) begin
                Result   <= fix_res;
                Zero     <= (fix_res == '0);
                Negative <= fix_res[WIDTH-1];
                Overflow <= ovf_r;
                CarryOUT <= 1'b0;
                Done     <= 1'b1;
            end
        end
    end
endmodule
